// File: rtl/motor_bridge_drv.sv
// H-bridge PWM driver: turns dir/en level commands into ramped IN1/IN2 PWM
// with a forced all-off dead time before every direction reversal.
module motor_bridge_drv #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned DUTY_MAX = 200,
  parameter int unsigned RAMP_DIV = 64,
  parameter int unsigned DEAD_CYC = 32
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             dir,
  input  logic             en,
  output logic             IN1,
  output logic             IN2,
  output logic             busy,
  output logic [CNT_W-1:0] duty
);

  // One shared timer paces both duty steps and the dead-time interval
  localparam int unsigned TMR_MAX = (RAMP_DIV > DEAD_CYC) ? RAMP_DIV : DEAD_CYC;
  localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  localparam logic [TMR_W-1:0] RAMP_LAST = TMR_W'(RAMP_DIV - 1);
  localparam logic [TMR_W-1:0] DEAD_LAST = TMR_W'(DEAD_CYC - 1);
  localparam logic [CNT_W-1:0] DMAX      = CNT_W'(DUTY_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RAMP,
    S_RUN,
    S_DECEL,
    S_DEAD
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] duty_nxt;
  logic [CNT_W-1:0] pwm_cnt;
  logic [TMR_W-1:0] tmr, tmr_nxt;
  logic             cur_dir, cur_dir_nxt;
  logic             step;
  logic             keep;
  logic             pwm_on;

  // State, duty, timer, PWM counter and registered bridge pins
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state   <= S_IDLE;
      duty    <= '0;
      tmr     <= '0;
      cur_dir <= 1'b0;
      pwm_cnt <= '0;
      IN1     <= 1'b0;
      IN2     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      duty    <= duty_nxt;
      tmr     <= tmr_nxt;
      cur_dir <= cur_dir_nxt;
      pwm_cnt <= pwm_cnt + 1'b1;
      IN1     <= cur_dir & pwm_on;
      IN2     <= ~cur_dir & pwm_on;
      busy    <= (state_nxt != S_IDLE);
    end
  end

  // Next-state, duty ramp and timer control
  always_comb begin
    state_nxt   = state;
    duty_nxt    = duty;
    tmr_nxt     = tmr;
    cur_dir_nxt = cur_dir;
    step        = (tmr == RAMP_LAST);
    keep        = en && (dir == cur_dir);
    pwm_on      = (pwm_cnt < duty);

    case (state)
      S_IDLE: begin
        duty_nxt = '0;
        tmr_nxt  = '0;
        if (en) begin
          cur_dir_nxt = dir;
          state_nxt   = S_RAMP;
        end
      end
      S_RAMP: begin
        tmr_nxt = step ? '0 : tmr + 1'b1;
        if (!keep) begin
          state_nxt = S_DECEL;
          tmr_nxt   = '0;
        end else if (duty >= DMAX) begin
          state_nxt = S_RUN;
          tmr_nxt   = '0;
          duty_nxt  = DMAX;
        end else if (step) begin
          duty_nxt = duty + 1'b1;
        end
      end
      S_RUN: begin
        duty_nxt = DMAX;
        tmr_nxt  = '0;
        if (!keep) begin
          state_nxt = S_DECEL;
        end
      end
      S_DECEL: begin
        tmr_nxt = step ? '0 : tmr + 1'b1;
        // Returning to the same command resumes the ramp without dead time
        if (keep) begin
          state_nxt = S_RAMP;
          tmr_nxt   = '0;
        end else if (duty == '0) begin
          state_nxt = S_DEAD;
          tmr_nxt   = '0;
        end else if (step) begin
          duty_nxt = duty - 1'b1;
        end
      end
      S_DEAD: begin
        duty_nxt = '0;
        if (tmr == DEAD_LAST) begin
          tmr_nxt = '0;
          if (en) begin
            cur_dir_nxt = dir;
            state_nxt   = S_RAMP;
          end else begin
            state_nxt = S_IDLE;
          end
        end else begin
          tmr_nxt = tmr + 1'b1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        duty_nxt  = '0;
        tmr_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_motor_bridge_drv.sv
// Bench for motor_bridge_drv: directed scenarios plus random dir/en traffic
// checked every cycle against a countdown-based behavioural model.
module tb_motor_bridge_drv;

  localparam int CNT_W = 4;
  localparam int DMAX  = 12;
  localparam int RDIV  = 2;
  localparam int DCYC  = 4;

  localparam int M_IDLE = 0;
  localparam int M_UP   = 1;
  localparam int M_RUN  = 2;
  localparam int M_DOWN = 3;
  localparam int M_DEAD = 4;

  logic             CLK = 1'b0;
  logic             RSTn;
  logic             dir;
  logic             en;
  logic             IN1;
  logic             IN2;
  logic             busy;
  logic [CNT_W-1:0] duty;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  int m_mode, m_duty, m_wait, m_pwm;
  bit m_dir, m_in1, m_in2, m_busy;

  int gap;
  int last_pin;

  motor_bridge_drv #(
    .CNT_W(CNT_W), .DUTY_MAX(DMAX), .RAMP_DIV(RDIV), .DEAD_CYC(DCYC)
  ) dut (
    .CLK(CLK), .RSTn(RSTn), .dir(dir), .en(en),
    .IN1(IN1), .IN2(IN2), .busy(busy), .duty(duty)
  );

  initial forever #5 CLK = ~CLK;

  task automatic model_reset();
    m_mode = M_IDLE; m_duty = 0; m_wait = 0; m_pwm = 0;
    m_dir = 1'b0; m_in1 = 1'b0; m_in2 = 1'b0; m_busy = 1'b0;
  endtask

  // One clock of the intended behaviour: pins reflect the previous duty, then
  // the duty level moves one step every RDIV clocks while ramping.
  task automatic model_clock(input bit e, input bit d);
    bit on, keep;
    on    = (m_pwm < m_duty);
    m_in1 = m_dir & on;
    m_in2 = !m_dir & on;
    m_pwm = (m_pwm + 1) % (1 << CNT_W);
    keep  = e && (d == m_dir);
    case (m_mode)
      M_IDLE: if (e) begin m_dir = d; m_mode = M_UP; m_wait = RDIV; end
      M_UP: begin
        if (!keep) begin m_mode = M_DOWN; m_wait = RDIV; end
        else if (m_duty == DMAX) m_mode = M_RUN;
        else begin
          m_wait--;
          if (m_wait == 0) begin m_duty++; m_wait = RDIV; end
        end
      end
      M_RUN: if (!keep) begin m_mode = M_DOWN; m_wait = RDIV; end
      M_DOWN: begin
        if (keep) begin m_mode = M_UP; m_wait = RDIV; end
        else if (m_duty == 0) begin m_mode = M_DEAD; m_wait = DCYC; end
        else begin
          m_wait--;
          if (m_wait == 0) begin m_duty--; m_wait = RDIV; end
        end
      end
      default: begin
        m_wait--;
        if (m_wait == 0) begin
          if (e) begin m_dir = d; m_mode = M_UP; m_wait = RDIV; end
          else m_mode = M_IDLE;
        end
      end
    endcase
    m_busy = (m_mode != M_IDLE);
  endtask

  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn) model_reset();
    else model_clock(en, dir);
  end

  // Cycle-by-cycle comparison against the model plus safety invariants
  always @(negedge CLK) begin
    if (chk_en) begin
      n_chk++;
      if (IN1 !== m_in1) begin n_fail++; $display("FAIL model_in1 t=%0t got %b expected %b", $time, IN1, m_in1); end
      n_chk++;
      if (IN2 !== m_in2) begin n_fail++; $display("FAIL model_in2 t=%0t got %b expected %b", $time, IN2, m_in2); end
      n_chk++;
      if (busy !== m_busy) begin n_fail++; $display("FAIL model_busy t=%0t got %b expected %b", $time, busy, m_busy); end
      n_chk++;
      if (duty !== CNT_W'(m_duty)) begin n_fail++; $display("FAIL model_duty t=%0t got %0d expected %0d", $time, duty, m_duty); end
      n_chk++;
      if ((IN1 & IN2) !== 1'b0) begin n_fail++; $display("FAIL shoot_through t=%0t IN1=%b IN2=%b expected not both 1", $time, IN1, IN2); end
      n_chk++;
      if (!(duty <= CNT_W'(DMAX))) begin n_fail++; $display("FAIL duty_limit t=%0t got %0d expected <= %0d", $time, duty, DMAX); end
      if (!RSTn) begin
        last_pin = 0; gap = 0;
      end else if (IN1 || IN2) begin
        if (last_pin != 0 && last_pin != (IN1 ? 1 : 2)) begin
          n_chk++;
          if (gap < DCYC) begin n_fail++; $display("FAIL reversal_gap t=%0t got %0d low clks expected >= %0d", $time, gap, DCYC); end
        end
        last_pin = IN1 ? 1 : 2;
        gap = 0;
      end else begin
        gap++;
      end
    end
  end

  task automatic clk_n(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wait_duty(input int val, input int budget, input string tag);
    int k;
    k = 0;
    while (duty !== CNT_W'(val) && k < budget) begin clk_n(1); k++; end
    n_chk++;
    if (duty !== CNT_W'(val)) begin n_fail++; $display("FAIL %s_timeout got duty %0d expected %0d within %0d clks", tag, duty, val, budget); end
  endtask

  task automatic test_reset();
    RSTn = 1'b0; en = 1'b0; dir = 1'b0;
    model_reset(); gap = 0; last_pin = 0;
    chk_en = 1'b1;
    #3;
    n_chk++;
    if ({IN1, IN2, busy, duty} !== '0) begin n_fail++; $display("FAIL reset_outputs got %b expected 0", {IN1, IN2, busy, duty}); end
    #20 RSTn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      clk_n(1);
      n_chk++;
      if (busy !== 1'b0 || duty !== '0) begin n_fail++; $display("FAIL reset_idle busy=%b duty=%0d expected 0/0", busy, duty); end
    end
  endtask

  task automatic test_start_fwd();
    int hi1, hi2;
    en = 1'b1; dir = 1'b1;
    clk_n(1);
    n_chk++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL start_busy got %b expected 1", busy); end
    clk_n(1);
    n_chk++;
    if (duty !== 4'd0) begin n_fail++; $display("FAIL start_duty_e2 got %0d expected 0", duty); end
    clk_n(1);
    n_chk++;
    if (duty !== 4'd1) begin n_fail++; $display("FAIL start_duty_e3 got %0d expected 1", duty); end
    clk_n(21);
    n_chk++;
    if (duty !== 4'd11) begin n_fail++; $display("FAIL start_duty_e24 got %0d expected 11", duty); end
    clk_n(1);
    n_chk++;
    if (duty !== 4'd12) begin n_fail++; $display("FAIL start_duty_e25 got %0d expected 12", duty); end
    clk_n(2);
    hi1 = 0; hi2 = 0;
    for (int i = 0; i < 16; i++) begin
      clk_n(1);
      hi1 += int'(IN1); hi2 += int'(IN2);
    end
    n_chk++;
    if (hi1 != 12) begin n_fail++; $display("FAIL start_in1_highs got %0d expected 12", hi1); end
    n_chk++;
    if (hi2 != 0) begin n_fail++; $display("FAIL start_in2_highs got %0d expected 0", hi2); end
  endtask

  task automatic test_reversal();
    bit seen2, bad1;
    dir = 1'b0;
    clk_n(1);
    clk_n(23);
    n_chk++;
    if (duty !== 4'd1) begin n_fail++; $display("FAIL rev_duty_e23 got %0d expected 1", duty); end
    clk_n(1);
    n_chk++;
    if (duty !== 4'd0) begin n_fail++; $display("FAIL rev_duty_e24 got %0d expected 0", duty); end
    clk_n(6);
    n_chk++;
    if (duty !== 4'd0 || busy !== 1'b1) begin n_fail++; $display("FAIL rev_dead_e30 duty=%0d busy=%b expected 0/1", duty, busy); end
    clk_n(1);
    n_chk++;
    if (duty !== 4'd1) begin n_fail++; $display("FAIL rev_restart_e31 got %0d expected 1", duty); end
    seen2 = 1'b0; bad1 = 1'b0;
    for (int i = 0; i < 40 && !seen2; i++) begin
      clk_n(1);
      if (IN1) bad1 = 1'b1;
      if (IN2) seen2 = 1'b1;
    end
    n_chk++;
    if (!seen2 || bad1) begin n_fail++; $display("FAIL rev_pins got in2_seen=%b in1_seen=%b expected 1/0", seen2, bad1); end
    wait_duty(12, 40, "rev_run");
    clk_n(2);
  endtask

  task automatic test_stop();
    en = 1'b0;
    clk_n(1);
    clk_n(24);
    n_chk++;
    if (duty !== 4'd0) begin n_fail++; $display("FAIL stop_duty_e24 got %0d expected 0", duty); end
    clk_n(4);
    n_chk++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL stop_busy_e28 got %b expected 1", busy); end
    clk_n(1);
    n_chk++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL stop_busy_e29 got %b expected 0", busy); end
  endtask

  task automatic test_abort_decel();
    en = 1'b1; dir = 1'b1;
    wait_duty(12, 40, "abort_run");
    clk_n(2);
    en = 1'b0;
    wait_duty(6, 40, "abort_fall");
    en = 1'b1;
    clk_n(2);
    n_chk++;
    if (duty !== 4'd6 || busy !== 1'b1) begin n_fail++; $display("FAIL abort_hold duty=%0d busy=%b expected 6/1", duty, busy); end
    clk_n(1);
    n_chk++;
    if (duty !== 4'd7) begin n_fail++; $display("FAIL abort_step got %0d expected 7", duty); end
    clk_n(10);
    n_chk++;
    if (duty !== 4'd12) begin n_fail++; $display("FAIL abort_top got %0d expected 12", duty); end
  endtask

  task automatic test_random();
    int cyc, len;
    cyc = 0;
    while (cyc < 10000) begin
      len = int'($urandom_range(1, 60));
      en  = ($urandom % 4) != 0;
      dir = 1'($urandom % 2);
      clk_n(len);
      cyc += len;
    end
  endtask

  task automatic test_reset_mid_run();
    en = 1'b1; dir = 1'($urandom % 2);
    wait_duty(12, 200, "rst_run");
    clk_n(3);
    #2 RSTn = 1'b0;
    #1;
    n_chk++;
    if ({IN1, IN2, busy, duty} !== '0) begin n_fail++; $display("FAIL rst_mid_run got %b expected 0", {IN1, IN2, busy, duty}); end
    en = 1'b0;
    #10 RSTn = 1'b1;
    clk_n(20);
    n_chk++;
    if (busy !== 1'b0 || duty !== '0) begin n_fail++; $display("FAIL rst_stay_idle busy=%b duty=%0d expected 0/0", busy, duty); end
  endtask

  initial begin
    test_reset();
    test_start_fwd();
    test_reversal();
    test_stop();
    test_abort_decel();
    test_random();
    test_reset_mid_run();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
